// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronises and debounces raw buttons on a millisecond tick,
// then reports single-button presses and rejects chords until every button is released.
module btn_conditioner #(
    parameter int N_BTN       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_MS = 20,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ticks_per_milli,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic             chord,
    output logic             ms_tick,
    output logic             state_dbg_o
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_MS - 1);

    typedef enum logic {
        IDLE         = 1'b0,
        WAIT_RELEASE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_q;
    logic [N_BTN-1:0]                  btn_sync;
    logic [15:0]                       tick_cnt_q;
    logic                              ms_tick_q;
    logic [N_BTN-1:0][CNT_W-1:0]       cnt_q;
    logic [N_BTN-1:0][CNT_W-1:0]       cnt_d;
    logic [N_BTN-1:0]                  level_q;
    logic [N_BTN-1:0]                  level_d;
    logic [N_BTN-1:0]                  press_q;
    logic                              chord_q;
    state_t                            state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // The >= compare lets the counter recover at once when the period is shortened mid-count.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            ms_tick_q  <= 1'b0;
        end else if (tick_cnt_q >= ticks_per_milli) begin
            tick_cnt_q <= '0;
            ms_tick_q  <= 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
            ms_tick_q  <= 1'b0;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (btn_sync[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (ms_tick_q) begin
                if (cnt_q[i] == DB_LAST) begin
                    level_d[i] = btn_sync[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // A press is reported only from IDLE; anything that happens while buttons are held is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            press_q <= '0;
            chord_q <= 1'b0;
        end else begin
            press_q <= '0;
            chord_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (level_q != '0) begin
                        if ((level_q & (level_q - N_BTN'(1))) == '0) begin
                            press_q <= level_q;
                        end else begin
                            chord_q <= 1'b1;
                        end
                        state_q <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (level_q == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign chord       = chord_q;
    assign ms_tick     = ms_tick_q;
    assign state_dbg_o = (state_q == WAIT_RELEASE);

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: randomized and directed button stimulus against a
// tick-arithmetic reference model, with a queue-based press/chord scoreboard.
module tb_btn_conditioner;

  localparam int N  = 4;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  tpm = 16'd9;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic         chord;
  logic         ms_tick;
  logic         state_dbg;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(
    .N_BTN(N), .SYNC_STAGES(2), .DEBOUNCE_MS(DB), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .ticks_per_milli(tpm), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .chord(chord),
    .ms_tick(ms_tick), .state_dbg_o(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: tick edges are computed arithmetically from the cycle index
  logic [36:0]  exp_q[$];
  int           k = 0;
  int           p = 10;
  logic [N-1:0] m_lvl = '0;
  logic [N-1:0] h0 = '0, h1 = '0, h2 = '0;
  int           mis_start[N];
  bit           mis_valid[N];
  bit           armed = 1'b1;
  bit           model_en = 1'b1;

  function automatic int ticks_upto(input int x, input int per);
    return (x >= 1) ? (x - 1) / per : 0;
  endfunction

  always begin
    @(posedge clk); #1;
    if (rst) begin
      k = 0;
      p = int'(tpm) + 1;
      m_lvl = '0;
      h0 = '0; h1 = '0; h2 = '0;
      for (int i = 0; i < N; i++) mis_valid[i] = 1'b0;
      armed = 1'b1;
      exp_q.delete();
    end else begin
      k++;
      h2 = h1; h1 = h0; h0 = btn_raw;
      for (int i = 0; i < N; i++) begin
        if (h2[i] == m_lvl[i]) begin
          mis_valid[i] = 1'b0;
        end else begin
          if (!mis_valid[i]) begin
            mis_valid[i] = 1'b1;
            mis_start[i] = k;
          end
          if (ticks_upto(k, p) - ticks_upto(mis_start[i] - 1, p) >= DB) begin
            m_lvl[i] = h2[i];
            mis_valid[i] = 1'b0;
          end
        end
      end
      if (armed && m_lvl != '0) begin
        if ($countones(m_lvl) > 1) exp_q.push_back({32'(k + 1), 1'b1, 4'b0000});
        else                       exp_q.push_back({32'(k + 1), 1'b0, m_lvl});
        armed = 1'b0;
      end else if (!armed && m_lvl == '0) begin
        armed = 1'b1;
      end
      if (model_en) begin
        check("btn_level", 32'(btn_level), 32'(m_lvl));
        check("ms_tick", 32'(ms_tick), 32'((k % p) == 0));
      end
    end
  end

  // monitor / scoreboard
  int           mon_k = 0;
  bit           prev_evt = 1'b0;
  bit           evt;
  logic [36:0]  e;
  int           press_cnt = 0;
  int           chord_cnt = 0;
  logic [N-1:0] last_press = '0;

  always begin
    @(posedge clk); #1;
    if (rst) begin
      mon_k = 0;
      prev_evt = 1'b0;
    end else begin
      mon_k++;
      while (exp_q.size() > 0 && int'(exp_q[0][36:5]) < mon_k) begin
        checks++; errors++;
        $display("FAIL missed_event: got nothing, expected press=%b chord=%b at cycle %0d",
                 exp_q[0][3:0], exp_q[0][4], exp_q[0][36:5]);
        void'(exp_q.pop_front());
      end
      evt = (btn_press != '0) || chord;
      if (evt) begin
        check("press_onehot", 32'($countones(btn_press) <= 1), 32'd1);
        check("press_chord_exclusive", 32'((btn_press != '0) && chord), 32'd0);
        check("no_back_to_back", 32'(prev_evt), 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: got press=%b chord=%b, expected none", btn_press, chord);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", 32'(mon_k), e[36:5]);
          check("event_press", 32'(btn_press), 32'(e[3:0]));
          check("event_chord", 32'(chord), 32'(e[4]));
        end
        if (btn_press != '0) begin
          press_cnt++;
          last_press = btn_press;
        end
        if (chord) chord_cnt++;
      end
      prev_evt = evt;
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [15:0] t);
    @(negedge clk);
    rst = 1'b1;
    tpm = t;
    model_en = 1'b1;
    @(posedge clk); #1;
    check("reset_outputs", 32'({btn_level, btn_press, chord, ms_tick}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic [N-1:0] v);
    @(negedge clk);
    btn_raw = v;
  endtask

  task automatic wait_level(input logic [N-1:0] v, input int budget, output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (btn_level == v) break;
      if (lat >= budget) begin
        checks++; errors++;
        $display("FAIL wait_level_timeout: got %b expected %b within %0d cycles", btn_level, v, budget);
        break;
      end
    end
  endtask

  int lat, pc0, cc0, n;
  logic [N-1:0] v;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // single press, tick period
    do_reset(16'd9);
    pc0 = press_cnt; cc0 = chord_cnt;
    drive(4'b0001);
    wait_level(4'b0001, 100, lat);
    check("single_latency_in_window", 32'(lat >= 33 && lat <= 42), 32'd1);
    @(posedge clk); #1;
    check("single_press_next_cycle", 32'(btn_press), 32'b0001);
    n = 0;
    while (!ms_tick && n < 20) begin @(posedge clk); #1; n++; end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ms_tick && n < 20);
    check("ms_tick_period", 32'(n), 32'd10);
    cyc(60);
    check("single_press_count", 32'(press_cnt - pc0), 32'd1);
    check("single_no_chord", 32'(chord_cnt - cc0), 32'd0);
    drive(4'b0000);
    wait_level(4'b0000, 60, lat);

    // bounce
    pc0 = press_cnt;
    for (int i = 0; i < 13; i++) begin
      drive(btn_raw ^ 4'b0100);
      cyc(14);
    end
    check("bounce_no_level", 32'(btn_level), 32'd0);
    check("bounce_no_press", 32'(press_cnt - pc0), 32'd0);
    wait_level(4'b0100, 60, lat);
    cyc(3);
    check("bounce_press_once", 32'(press_cnt - pc0), 32'd1);
    check("bounce_press_value", 32'(last_press), 32'b0100);
    drive(4'b0000);
    wait_level(4'b0000, 60, lat);

    // chord
    pc0 = press_cnt; cc0 = chord_cnt;
    drive(4'b1001);
    wait_level(4'b1001, 60, lat);
    cyc(3);
    check("chord_pulse", 32'(chord_cnt - cc0), 32'd1);
    check("chord_no_press", 32'(press_cnt - pc0), 32'd0);
    drive(4'b0000);
    wait_level(4'b0000, 60, lat);
    drive(4'b0010);
    wait_level(4'b0010, 60, lat);
    cyc(3);
    check("after_chord_press", 32'(press_cnt - pc0), 32'd1);
    check("after_chord_value", 32'(last_press), 32'b0010);
    drive(4'b0000);
    wait_level(4'b0000, 60, lat);

    // held plus second button
    pc0 = press_cnt; cc0 = chord_cnt;
    drive(4'b0001);
    wait_level(4'b0001, 60, lat);
    cyc(3);
    drive(4'b0101);
    wait_level(4'b0101, 60, lat);
    cyc(3);
    check("held_second_no_press", 32'(press_cnt - pc0), 32'd1);
    check("held_second_no_chord", 32'(chord_cnt - cc0), 32'd0);
    drive(4'b0100);
    wait_level(4'b0100, 60, lat);
    cyc(3);
    check("partial_release_silent", 32'(press_cnt - pc0), 32'd1);
    drive(4'b0000);
    wait_level(4'b0000, 60, lat);
    drive(4'b0100);
    wait_level(4'b0100, 60, lat);
    cyc(3);
    check("repress_reported", 32'(press_cnt - pc0), 32'd2);
    check("repress_value", 32'(last_press), 32'b0100);
    drive(4'b0000);
    wait_level(4'b0000, 60, lat);

    // reset mid-debounce
    pc0 = press_cnt;
    drive(4'b1000);
    cyc(20);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_outputs", 32'({btn_level, btn_press, chord, ms_tick}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("after_reset_level", 32'(btn_level), 32'd0);
    wait_level(4'b1000, 100, lat);
    check("midreset_latency", 32'(lat >= 32 && lat <= 41), 32'd1);
    cyc(3);
    check("midreset_press", 32'(press_cnt - pc0), 32'd1);
    check("midreset_value", 32'(last_press), 32'b1000);
    drive(4'b0000);
    wait_level(4'b0000, 60, lat);

    // tick edge cases
    do_reset(16'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("tick_every_cycle", 32'(ms_tick), 32'd1);
    end
    drive(4'b0001);
    wait_level(4'b0001, 30, lat);
    check("fast_tick_latency", 32'(lat), 32'd6);
    drive(4'b0000);
    wait_level(4'b0000, 30, lat);

    do_reset(16'd100);
    cyc(30);
    model_en = 1'b0;
    tpm = 16'd5;
    @(posedge clk); #1;
    check("tick_after_lowering", 32'(ms_tick), 32'd1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ms_tick && n < 20);
    check("tick_period_after_lowering", 32'(n), 32'd6);

    // randomized
    for (int r = 0; r < 3; r++) begin
      do_reset(16'($urandom_range(0, 6)));
      for (int s = 0; s < 60; s++) begin
        n = $urandom_range(0, 9);
        if (n < 4)      v = 4'(1 << $urandom_range(0, 3));
        else if (n < 6) v = 4'b0000;
        else            v = 4'($urandom_range(0, 15));
        drive(v);
        cyc($urandom_range(1, 60));
      end
      drive(4'b0000);
      cyc(80);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the four raw push-button inputs before they reach the game controller.
- Synchronises each button to clk and debounces it on a millisecond time base derived from ticks_per_milli.
- Emits clean debounced levels plus a single-cycle one-hot press pulse per valid single-button press.
- Chorded presses are rejected, and no further press is reported until every button has been released.

Parameters:
- N_BTN, 4, number of buttons.
- SYNC_STAGES, 2, synchroniser flop depth (minimum 2).
- DEBOUNCE_MS, 20, number of consecutive millisecond ticks a raw change must persist before it is accepted (minimum 1).
- CNT_W, 8, width of each per-button debounce counter; must hold DEBOUNCE_MS.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- ticks_per_milli  in  16  clk cycles per ms minus one; the ms tick period is ticks_per_milli+1 cycles.
- btn_raw  in  N_BTN  asynchronous active-high button inputs.
- btn_level  out  N_BTN  debounced button state.
- btn_press  out  N_BTN  one-cycle one-hot pulse on each accepted press.
- chord  out  1  one-cycle pulse when a multi-button press is rejected.
- ms_tick  out  1  one-cycle pulse every ticks_per_milli+1 cycles.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. rst clears all of the following to 0 in the same edge:
  - synchroniser flops, tick counter and debounce counters;
  - btn_level, btn_press, chord, ms_tick;
  - FSM, which goes to IDLE.
  - Reset mid-debounce discards all progress.
  - A button held through reset release is debounced afresh and reported as a normal press.
- Tick generator:
  - tick_cnt increments every cycle.
  - When tick_cnt >= ticks_per_milli: tick_cnt <= 0 and ms_tick is asserted for that one cycle (registered).
  - The >= compare guarantees recovery if ticks_per_milli is lowered mid-count.
  - ticks_per_milli = 0 gives ms_tick every cycle.
- Synchroniser: btn_raw passes through SYNC_STAGES flops to give btn_sync. There is no other use of btn_raw.
- Debounce, per bit i:
  - If btn_sync[i] == btn_level[i]: cnt[i] <= 0.
  - Else on ms_tick: if cnt[i] == DEBOUNCE_MS-1, then btn_level[i] <= btn_sync[i] and cnt[i] <= 0; otherwise cnt[i] <= cnt[i]+1.
  - Without ms_tick: hold cnt[i].
  - Any return of btn_sync to btn_level before acceptance restarts the count from 0.
  - Acceptance latency after the btn_sync change: between (DEBOUNCE_MS-1)*P+1 and DEBOUNCE_MS*P cycles, where P = ticks_per_milli+1.
  - Press and release are debounced identically.
- Press FSM, evaluated on btn_level:
  - IDLE:
    - btn_level == 0: stay.
    - Exactly one bit set: btn_press <= btn_level for one cycle, then go to WAIT_RELEASE.
    - Two or more bits set (including simultaneous acceptance in the same cycle): chord <= 1 for one cycle with no btn_press, then go to WAIT_RELEASE.
  - WAIT_RELEASE:
    - Stay while btn_level != 0.
    - Additional buttons pressed here produce no btn_press and no chord.
    - When btn_level == 0: go to IDLE.
  - btn_press and chord are registered: they assert the cycle after btn_level first becomes nonzero in IDLE.
  - btn_press is always 0 or one-hot.
  - btn_press and chord are never asserted together.
  - Neither is asserted in consecutive cycles.
  - A re-press is reported only after a full debounced release of all buttons followed by a new debounced press.

Test Plan:
- Timing setup for scenarios 1–4: ticks_per_milli=9 (P=10), DEBOUNCE_MS=4, SYNC_STAGES=2.
1. Single press: btn_raw=0001, held 100 cycles.
   - btn_level=0001 appears 33–42 cycles after the raw edge.
   - btn_press=0001 for exactly one cycle, the next cycle.
   - chord stays 0.
   - ms_tick period is exactly 10 cycles.
2. Bounce: btn_raw[2] toggles every 15 cycles for 200 cycles, then holds 1.
   - No btn_level change and no btn_press during bouncing.
   - One btn_press=0100 after stable hold plus the debounce latency.
3. Chord: btn_raw 0000→1001 in the same cycle.
   - btn_level=1001, chord pulses once, btn_press stays 0.
   - Release both, then press 0010: btn_press=0010 once.
4. Held plus second button: press 0001 (btn_press=0001 once); while it is held, press 0100.
   - btn_level=0101 with no further btn_press and no chord.
   - Release 0001 only: nothing is reported.
   - Release 0100, then re-press 0100: btn_press=0100.
5. Reset mid-operation: btn_raw=1000 held, rst asserted 1 cycle midway through debounce and released with the button still held.
   - All outputs 0 during and after reset.
   - btn_press=1000 reported a full debounce latency after rst deasserts.
6. Tick edge cases: ticks_per_milli=0.
   - ms_tick high every cycle.
   - Press latency equals 2 sync + DEBOUNCE_MS cycles.
   - Switching ticks_per_milli from 100 to 5 mid-count gives ms_tick within 1 cycle, then a period of 6 cycles.
